icd_spi_slave: RTL and testbench

- SPI-slave front end of the In-Circuit Debugger, directly upstream of the ICD command controller.
- Samples the asynchronous USB/FTDI SPI pins (mode 0, MSB-first) in the clk6x domain and delivers received bytes as single-cycle strobes: header strobe for the first byte after CSn falls, data-byte strobe for every later byte.
- Accepts response bytes from the controller and shifts each one out on MISO during the next SPI byte.

---
 rtl/icd_spi_slave.sv | 191 +++++++++++++++++++
 tb/tb_icd_spi_slave.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/icd_spi_slave.sv
// icd_spi_slave: SPI mode-0 slave front end for the In-Circuit Debugger.
// Synchronizes SCK/CSn/MOSI into clk6x, strobes RX bytes, shifts TX bytes.
module icd_spi_slave #(
  parameter int          SYNC_STAGES = 2,
  parameter logic [7:0]  IDLE_BYTE   = 8'hFF
) (
  input  logic       clk6x,
  input  logic       resetn,
  input  logic       spi_csn_i,
  input  logic       spi_sck_i,
  input  logic       spi_mosi_i,
  output logic       spi_miso_o,
  output logic       spi_miso_oe_o,
  output logic [7:0] rx_byte_o,
  output logic       rx_hdr_en_o,
  output logic       rx_db_en_o,
  input  logic [7:0] tx_byte_i,
  input  logic       tx_en_i,
  output logic       cs_active_o,
  output logic       tx_ovr_o
);

  localparam int NS = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

  logic [NS-1:0] csn_sync_q, csn_sync_d;
  logic [NS-1:0] sck_sync_q, sck_sync_d;
  logic [NS-1:0] mosi_sync_q, mosi_sync_d;
  logic          csn_prev_q, csn_prev_d;
  logic          sck_prev_q, sck_prev_d;
  logic [NS:0]   vld_q, vld_d;
  logic          armed_q, armed_d;

  logic          cs_active_q, cs_active_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [6:0]    rxsr_q, rxsr_d;
  logic [7:0]    rx_byte_q, rx_byte_d;
  logic          hdr_en_q, hdr_en_d;
  logic          db_en_q, db_en_d;
  logic          first_byte_q, first_byte_d;
  logic          load_pending_q, load_pending_d;
  logic [7:0]    txsr_q, txsr_d;
  logic [7:0]    txbuf_q, txbuf_d;
  logic          txbuf_valid_q, txbuf_valid_d;
  logic          tx_ovr_q, tx_ovr_d;

  logic csn_s, sck_s, mosi_s;
  logic cs_fall, cs_rise;
  logic sck_rise, sck_fall;
  logic consume;

  assign csn_s  = csn_sync_q[NS-1];
  assign sck_s  = sck_sync_q[NS-1];
  assign mosi_s = mosi_sync_q[NS-1];

  // Synchronizer shift, edge history and post-reset arming of CSn.
  always_comb begin
    csn_sync_d  = {csn_sync_q[NS-2:0], spi_csn_i};
    sck_sync_d  = {sck_sync_q[NS-2:0], spi_sck_i};
    mosi_sync_d = {mosi_sync_q[NS-2:0], spi_mosi_i};
    csn_prev_d  = csn_s;
    sck_prev_d  = sck_s;
    vld_d       = {vld_q[NS-1:0], 1'b1};
    // A frame already running at reset release must not look like a fall.
    armed_d     = armed_q | (vld_q[NS] & csn_s);
  end

  assign cs_fall  = armed_q & csn_prev_q & ~csn_s;
  assign cs_rise  = ~csn_prev_q & csn_s;
  assign sck_rise = cs_active_q & ~cs_rise & ~sck_prev_q & sck_s;
  assign sck_fall = cs_active_q & ~cs_rise & sck_prev_q & ~sck_s;

  // Frame, receive shifter, transmit shifter and TX buffer next state.
  always_comb begin
    cs_active_d    = cs_active_q;
    bit_cnt_d      = bit_cnt_q;
    rxsr_d         = rxsr_q;
    rx_byte_d      = rx_byte_q;
    hdr_en_d       = 1'b0;
    db_en_d        = 1'b0;
    first_byte_d   = first_byte_q;
    load_pending_d = load_pending_q;
    txsr_d         = txsr_q;
    txbuf_d        = txbuf_q;
    txbuf_valid_d  = txbuf_valid_q;
    tx_ovr_d       = tx_ovr_q;
    consume        = 1'b0;

    if (cs_fall) begin
      cs_active_d    = 1'b1;
      bit_cnt_d      = 3'd0;
      first_byte_d   = 1'b1;
      tx_ovr_d       = 1'b0;
      txsr_d         = IDLE_BYTE;
      txbuf_valid_d  = 1'b0;
      load_pending_d = 1'b0;
    end else if (cs_rise) begin
      cs_active_d    = 1'b0;
      bit_cnt_d      = 3'd0;
      load_pending_d = 1'b0;
    end else begin
      if (sck_rise) begin
        rxsr_d    = {rxsr_q[5:0], mosi_s};
        bit_cnt_d = bit_cnt_q + 3'd1;
        if (bit_cnt_q == 3'd7) begin
          rx_byte_d      = {rxsr_q, mosi_s};
          hdr_en_d       = first_byte_q;
          db_en_d        = ~first_byte_q;
          first_byte_d   = 1'b0;
          load_pending_d = 1'b1;
        end
      end
      if (sck_fall) begin
        if (load_pending_q) begin
          consume        = 1'b1;
          load_pending_d = 1'b0;
          txbuf_valid_d  = 1'b0;
          // A response arriving on the load edge goes straight out.
          if (tx_en_i)
            txsr_d = tx_byte_i;
          else if (txbuf_valid_q)
            txsr_d = txbuf_q;
          else
            txsr_d = IDLE_BYTE;
        end else if (bit_cnt_q != 3'd0) begin
          txsr_d = {txsr_q[6:0], 1'b0};
        end
      end
    end

    if (tx_en_i && !consume) begin
      txbuf_d       = tx_byte_i;
      txbuf_valid_d = 1'b1;
      if (txbuf_valid_q && !cs_fall)
        tx_ovr_d = 1'b1;
    end
  end

  // All state registers with synchronous active-low reset.
  always_ff @(posedge clk6x) begin
    if (!resetn) begin
      csn_sync_q     <= '1;
      sck_sync_q     <= '0;
      mosi_sync_q    <= '0;
      csn_prev_q     <= 1'b1;
      sck_prev_q     <= 1'b0;
      vld_q          <= '0;
      armed_q        <= 1'b0;
      cs_active_q    <= 1'b0;
      bit_cnt_q      <= 3'd0;
      rxsr_q         <= '0;
      rx_byte_q      <= '0;
      hdr_en_q       <= 1'b0;
      db_en_q        <= 1'b0;
      first_byte_q   <= 1'b0;
      load_pending_q <= 1'b0;
      txsr_q         <= IDLE_BYTE;
      txbuf_q        <= '0;
      txbuf_valid_q  <= 1'b0;
      tx_ovr_q       <= 1'b0;
    end else begin
      csn_sync_q     <= csn_sync_d;
      sck_sync_q     <= sck_sync_d;
      mosi_sync_q    <= mosi_sync_d;
      csn_prev_q     <= csn_prev_d;
      sck_prev_q     <= sck_prev_d;
      vld_q          <= vld_d;
      armed_q        <= armed_d;
      cs_active_q    <= cs_active_d;
      bit_cnt_q      <= bit_cnt_d;
      rxsr_q         <= rxsr_d;
      rx_byte_q      <= rx_byte_d;
      hdr_en_q       <= hdr_en_d;
      db_en_q        <= db_en_d;
      first_byte_q   <= first_byte_d;
      load_pending_q <= load_pending_d;
      txsr_q         <= txsr_d;
      txbuf_q        <= txbuf_d;
      txbuf_valid_q  <= txbuf_valid_d;
      tx_ovr_q       <= tx_ovr_d;
    end
  end

  assign spi_miso_o    = cs_active_q ? txsr_q[7] : 1'b1;
  assign spi_miso_oe_o = cs_active_q;
  assign rx_byte_o     = rx_byte_q;
  assign rx_hdr_en_o   = hdr_en_q;
  assign rx_db_en_o    = db_en_q;
  assign cs_active_o   = cs_active_q;
  assign tx_ovr_o      = tx_ovr_q;

endmodule

// File: tb/tb_icd_spi_slave.sv
// tb_icd_spi_slave: directed vectors for the ICD SPI slave.
// Master bit-bangs SCK at 4 MHz (6 clk6x cycles per half period).
module tb_icd_spi_slave;

  localparam int HALF = 6;
  localparam int SYNC = 2;

  logic       clk6x = 1'b0;
  logic       resetn;
  logic       csn, sck, mosi;
  logic       miso, miso_oe;
  logic [7:0] rx_byte;
  logic       hdr_en, db_en;
  logic [7:0] tx_byte;
  logic       tx_en;
  logic       cs_active, tx_ovr;

  int errs = 0;
  int checks = 0;

  logic [8:0] sq[$];

  typedef struct {
    logic       nf;
    logic [7:0] mosi;
    logic       hdr;
    logic [7:0] miso;
    logic       echo;
  } vec_t;

  vec_t tbl[7];

  always #10 clk6x = ~clk6x;

  icd_spi_slave #(.SYNC_STAGES(SYNC), .IDLE_BYTE(8'hFF)) dut (
    .clk6x(clk6x),
    .resetn(resetn),
    .spi_csn_i(csn),
    .spi_sck_i(sck),
    .spi_mosi_i(mosi),
    .spi_miso_o(miso),
    .spi_miso_oe_o(miso_oe),
    .rx_byte_o(rx_byte),
    .rx_hdr_en_o(hdr_en),
    .rx_db_en_o(db_en),
    .tx_byte_i(tx_byte),
    .tx_en_i(tx_en),
    .cs_active_o(cs_active),
    .tx_ovr_o(tx_ovr)
  );

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk6x) begin
    if (hdr_en || db_en) begin
      sq.push_back({hdr_en, rx_byte});
      chk("strobe_exclusive", {31'd0, hdr_en & db_en}, 0);
      chk("strobe_selected", {31'd0, cs_active}, 1);
    end
  end

  task automatic spi_bits(input logic [7:0] tx, input int n,
                          output logic [7:0] rx);
    rx = '0;
    for (int i = 0; i < n; i++) begin
      mosi = tx[7-i];
      repeat (HALF) @(negedge clk6x);
      rx = {rx[6:0], miso};
      sck = 1'b1;
      repeat (HALF) @(negedge clk6x);
      sck = 1'b0;
    end
  endtask

  task automatic cs_start();
    @(negedge clk6x);
    csn = 1'b0;
    repeat (8) @(negedge clk6x);
  endtask

  task automatic cs_end();
    repeat (HALF) @(negedge clk6x);
    csn = 1'b1;
    repeat (8) @(negedge clk6x);
  endtask

  task automatic pulse(input logic [7:0] b);
    @(negedge clk6x);
    tx_byte = b;
    tx_en = 1'b1;
    @(negedge clk6x);
    tx_en = 1'b0;
  endtask

  task automatic echo_resp();
    int t;
    t = 0;
    while (!(hdr_en || db_en) && t < 400) begin
      @(negedge clk6x);
      t++;
    end
    chk("echo_strobe_seen", {31'd0, t < 400}, 1);
    tx_byte = rx_byte;
    tx_en = 1'b1;
    @(negedge clk6x);
    tx_en = 1'b0;
  endtask

  task automatic chk_strobe(input string name, input logic h,
                            input logic [7:0] b);
    logic [8:0] e;
    chk({name, "_count"}, sq.size(), 1);
    if (sq.size() > 0) begin
      e = sq.pop_front();
      chk({name, "_kind"}, {31'd0, e[8]}, {31'd0, h});
      chk({name, "_byte"}, {24'd0, e[7:0]}, {24'd0, b});
    end
    sq.delete();
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] rd;

    tbl[0] = '{1'b1, 8'h11, 1'b1, 8'hFF, 1'b0};
    tbl[1] = '{1'b0, 8'h34, 1'b0, 8'hFF, 1'b0};
    tbl[2] = '{1'b0, 8'h12, 1'b0, 8'hFF, 1'b0};
    tbl[3] = '{1'b0, 8'h00, 1'b0, 8'hFF, 1'b0};
    tbl[4] = '{1'b1, 8'hA5, 1'b1, 8'hFF, 1'b1};
    tbl[5] = '{1'b0, 8'h3C, 1'b0, 8'hA5, 1'b1};
    tbl[6] = '{1'b0, 8'h7E, 1'b0, 8'h3C, 1'b1};

    resetn = 1'b0;
    csn = 1'b1;
    sck = 1'b0;
    mosi = 1'b0;
    tx_en = 1'b0;
    tx_byte = '0;
    repeat (4) @(negedge clk6x);
    chk("rst_rx_byte", {24'd0, rx_byte}, 0);
    chk("rst_hdr", {31'd0, hdr_en}, 0);
    chk("rst_db", {31'd0, db_en}, 0);
    chk("rst_miso", {31'd0, miso}, 1);
    chk("rst_oe", {31'd0, miso_oe}, 0);
    chk("rst_cs_active", {31'd0, cs_active}, 0);
    chk("rst_ovr", {31'd0, tx_ovr}, 0);
    resetn = 1'b1;
    repeat (8) @(negedge clk6x);

    for (int i = 0; i < 7; i++) begin
      if (tbl[i].nf) begin
        if (i > 0) cs_end();
        cs_start();
        chk($sformatf("vec%0d_cs_active", i), {31'd0, cs_active}, 1);
        chk($sformatf("vec%0d_oe", i), {31'd0, miso_oe}, 1);
      end
      if (tbl[i].echo) begin
        fork
          spi_bits(tbl[i].mosi, 8, rd);
          echo_resp();
        join
      end else begin
        spi_bits(tbl[i].mosi, 8, rd);
      end
      repeat (2) @(negedge clk6x);
      chk_strobe($sformatf("vec%0d", i), tbl[i].hdr, tbl[i].mosi);
      chk($sformatf("vec%0d_miso", i), {24'd0, rd}, {24'd0, tbl[i].miso});
    end
    cs_end();
    chk("frame_end_cs_active", {31'd0, cs_active}, 0);
    chk("frame_end_miso", {31'd0, miso}, 1);

    // Partial byte then a fresh frame.
    cs_start();
    spi_bits(8'hF0, 5, rd);
    cs_end();
    chk("partial_nostrobe", sq.size(), 0);
    cs_start();
    spi_bits(8'h22, 8, rd);
    repeat (2) @(negedge clk6x);
    chk_strobe("after_partial", 1'b1, 8'h22);
    cs_end();

    // Overrun: two responses before the load edge.
    cs_start();
    pulse(8'h01);
    repeat (3) @(negedge clk6x);
    pulse(8'h02);
    chk("ovr_set", {31'd0, tx_ovr}, 1);
    spi_bits(8'h40, 8, rd);
    chk("ovr_miso0", {24'd0, rd}, 8'hFF);
    spi_bits(8'h00, 8, rd);
    chk("ovr_miso1", {24'd0, rd}, 8'h02);
    cs_end();
    chk("ovr_sticky", {31'd0, tx_ovr}, 1);
    cs_start();
    chk("ovr_clear_on_fall", {31'd0, tx_ovr}, 0);
    cs_end();
    sq.delete();

    // Response coincident with the load edge bypasses the buffer.
    cs_start();
    spi_bits(8'h99, 7, rd);
    pulse(8'h33);
    spi_bits(8'h80, 1, rd);
    repeat (SYNC) @(negedge clk6x);
    tx_byte = 8'h5A;
    tx_en = 1'b1;
    @(negedge clk6x);
    tx_en = 1'b0;
    spi_bits(8'h6B, 8, rd);
    chk("bypass_miso", {24'd0, rd}, 8'h5A);
    chk("bypass_no_ovr", {31'd0, tx_ovr}, 0);
    repeat (2) @(negedge clk6x);
    chk("bypass_rx_byte", {24'd0, rx_byte}, 8'h6B);
    sq.delete();
    cs_end();

    // Reset mid-byte, rest of frame ignored.
    cs_start();
    pulse(8'h11);
    pulse(8'h22);
    spi_bits(8'hC3, 4, rd);
    @(negedge clk6x);
    resetn = 1'b0;
    @(negedge clk6x);
    resetn = 1'b1;
    chk("mid_rst_rx_byte", {24'd0, rx_byte}, 0);
    chk("mid_rst_cs_active", {31'd0, cs_active}, 0);
    chk("mid_rst_oe", {31'd0, miso_oe}, 0);
    chk("mid_rst_miso", {31'd0, miso}, 1);
    chk("mid_rst_ovr", {31'd0, tx_ovr}, 0);
    spi_bits(8'h30, 4, rd);
    spi_bits(8'h5A, 8, rd);
    repeat (4) @(negedge clk6x);
    chk("mid_rst_nostrobe", sq.size(), 0);
    chk("mid_rst_still_idle", {31'd0, cs_active}, 0);
    cs_end();
    cs_start();
    chk("post_rst_cs_active", {31'd0, cs_active}, 1);
    spi_bits(8'h81, 8, rd);
    repeat (2) @(negedge clk6x);
    chk_strobe("post_rst", 1'b1, 8'h81);
    chk("post_rst_miso", {24'd0, rd}, 8'hFF);
    cs_end();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
